alu_mult_sequencer: RTL and testbench
=====================================

ALU_MULT_SEQUENCER -- requirements
Module: alu_mult_sequencer

Purpose: a multi-cycle 32x32 multiplier that keeps no adder or shifter of its own. Every add and shift goes through the shared ALU over its command and result ports.

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports are named clk and reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 in_multiplicand_32  input  32  operand A, captured when start is accepted.
REQ-006 in_multiplier_32  input  32  operand B, captured when start is accepted.
REQ-007 in_alu_result_32  input  32  ALUResult returned by the shared ALU (combinational, same cycle).
REQ-008 out_alu_op_4  output  4  ALUOperation code driven to the ALU.
REQ-009 out_alu_a_32  output  32  ALU operand A.
REQ-010 out_alu_b_32  output  32  ALU operand B.
REQ-011 out_alu_shamt_5  output  5  ALU shift amount.
REQ-012 busy  output  1  high while in ADD, SHIFT or DONE.
REQ-013 done  output  1  one-cycle pulse; product is valid.
REQ-014 out_product_32  output  32  low 32 bits of A*B; held until the next accepted start.

Function
REQ-015 ALU op codes SHALL be: AND=4'b0000, ADD=4'b0011, SLL=4'b0101. The ALU's Zero output is not used.
REQ-016 FSM states SHALL be IDLE, ADD, SHIFT and DONE; the registered state is the only control state.
REQ-017 IDLE with start=1: mcand<=in_multiplicand_32, mplier<=in_multiplier_32, acc<=0, next state ADD.
REQ-018 IDLE with start=0: remain in IDLE; registers unchanged.
REQ-019 ADD with mplier==0: out_product_32<=acc, next state DONE; acc unchanged.
REQ-020 ADD with mplier!=0: drive op=ADD, A=acc, B=mcand.
- acc<=in_alu_result_32 only if mplier[0]=1, otherwise acc holds.
- next state SHIFT.
REQ-021 SHIFT: drive op=SLL, A=0, B=mcand, shamt=5'd1.
- mcand<=in_alu_result_32.
- mplier<=mplier>>1 (logical).
- next state ADD.
REQ-022 ADD with mplier==0, and the IDLE and DONE states, SHALL drive op=AND, A=0, B=0, shamt=0.
REQ-023 DONE: done=1 for exactly this cycle, next state IDLE.
REQ-024 Arithmetic SHALL be modulo 2^32; carries out of bit 31 are discarded and there is no overflow flag.
REQ-025 Latency: start accepted in cycle T, k = index of the highest set bit of B. done SHALL assert in:
- cycle T+2k+4 when B!=0;
- cycle T+2 when B==0.
- Maximum is T+66.
REQ-026 start while busy=1 (including in DONE) SHALL be ignored; no operand capture and no effect on the running operation.
REQ-027 Operand inputs SHALL be don't-care except in the cycle where start is accepted.
REQ-028 busy SHALL be 0 in IDLE and 1 in ADD, SHIFT and DONE; done implies busy.
REQ-029 A start accepted in the cycle right after DONE SHALL begin a new operation normally.

Reset
REQ-030 On reset=1 at a clock edge the following SHALL hold, regardless of the current state:
- state<=IDLE;
- acc, mcand, mplier and out_product_32 <=0;
- done=0 and busy=0.
REQ-031 Reset SHALL override start in the same cycle.
REQ-032 Reset mid-operation SHALL abort with no done pulse, and out_product_32 SHALL read 0.
REQ-033 After reset the ALU outputs SHALL drive op=AND, A=0, B=0, shamt=0.

Verification
REQ-034 3 x 5 -> done at T+8, product=15, exactly one done pulse; busy high from T+1 to T+8.
REQ-035 0x1234 x 0 -> done at T+2, product=0; ALU op stays AND throughout.
REQ-036 0xFFFFFFFF x 0xFFFFFFFF -> done at T+66, product=0x00000001 (wrap-around).
REQ-037 7 x 0x80000000 -> done at T+66, product=0x80000000. Also, start pulsed with 1 x 1 at T+10 -> ignored.
REQ-038 6 x 9 with reset at T+3 -> no done pulse, busy=0 and product=0 at T+4. Then 6 x 9 started at T+5 -> done at T+5+10=T+15 (k=3), product=54.
REQ-039 Check every cycle that the ALU command matches REQ-020/021/022: a reference ALU model driven by the out_alu_* ports must return in_alu_result_32.

Source files
------------

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 32x32 multiplier (low 32 bits of the product).
// All adds and shifts are issued to an external shared ALU.
module alu_mult_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in_multiplicand_32,
   input  logic [31:0] in_multiplier_32,
   input  logic [31:0] in_alu_result_32,
   output logic [3:0]  out_alu_op_4,
   output logic [31:0] out_alu_a_32,
   output logic [31:0] out_alu_b_32,
   output logic [4:0]  out_alu_shamt_5,
   output logic        busy,
   output logic        done,
   output logic [31:0] out_product_32
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_e;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0101;

   state_e      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] prod_q, prod_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      acc_d           = acc_q;
      mcand_d         = mcand_q;
      mplier_d        = mplier_q;
      prod_d          = prod_q;
      out_alu_op_4    = OP_AND;
      out_alu_a_32    = '0;
      out_alu_b_32    = '0;
      out_alu_shamt_5 = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = in_multiplicand_32;
               mplier_d = in_multiplier_32;
               acc_d    = '0;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            if (mplier_q == '0) begin
               prod_d  = acc_q;
               state_d = S_DONE;
            end else begin
               out_alu_op_4 = OP_ADD;
               out_alu_a_32 = acc_q;
               out_alu_b_32 = mcand_q;
               // ALU add is always issued; only kept when this bit is set
               if (mplier_q[0]) acc_d = in_alu_result_32;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            out_alu_op_4    = OP_SLL;
            out_alu_b_32    = mcand_q;
            out_alu_shamt_5 = 5'd1;
            mcand_d         = in_alu_result_32;
            mplier_d        = mplier_q >> 1;
            state_d         = S_ADD;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign out_product_32 = prod_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer with a reference shared ALU.
module tb_alu_mult_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] mc;
   logic [31:0] mp;
   logic [31:0] alu_res;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_shamt;
   logic        busy;
   logic        done;
   logic [31:0] product;

   typedef struct {
      logic [31:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;
   bit   armed;
   bit   non_and;

   alu_mult_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .in_multiplicand_32 (mc),
      .in_multiplier_32   (mp),
      .in_alu_result_32   (alu_res),
      .out_alu_op_4       (alu_op),
      .out_alu_a_32       (alu_a),
      .out_alu_b_32       (alu_b),
      .out_alu_shamt_5    (alu_shamt),
      .busy               (busy),
      .done               (done),
      .out_product_32     (product)
   );

   // reference ALU: SLL shifts operand B by shamt
   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0011: alu_res = alu_a + alu_b;
         4'b0101: alu_res = alu_b << alu_shamt;
         default: alu_res = '0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // monitor: ALU command legality every cycle, scoreboard on done
   always @(negedge clk) begin
      if (armed) begin
         if (alu_op != 4'b0000) non_and = 1'b1;
         chk("op_legal", 32'(alu_op == 4'b0000 || alu_op == 4'b0011 ||
                             alu_op == 4'b0101), 32'd1);
         if (alu_op == 4'b0101)
            chk("sll_cmd", {alu_a, 27'd0, alu_shamt} == {32'd0, 27'd0, 5'd1}
                ? 32'd1 : 32'd0, 32'd1);
         if (alu_op == 4'b0000)
            chk("and_cmd", alu_a | alu_b | 32'(alu_shamt), 32'd0);
         if (!busy || done)
            chk("idle_op", 32'(alu_op), 32'd0);
         if (done) begin
            chk("done_busy", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("product", product, e.prod);
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat,
                      input int ign);
      int t;
      bit busy_ok;
      start   = 1'b1;
      mc      = a;
      mp      = b;
      t       = cyc;
      non_and = 1'b0;
      sb.push_back('{exp, t + lat});
      @(negedge clk);
      start   = 1'b0;
      mc      = $urandom;
      mp      = $urandom;
      busy_ok = 1'b1;
      for (int i = 1; i <= lat; i++) begin
         if (!busy) busy_ok = 1'b0;
         if (ign != 0 && cyc == t + ign) begin
            start = 1'b1;
            mc    = 32'd1;
            mp    = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_window", 32'(busy_ok), 32'd1);
      chk("idle_after", 32'(busy), 32'd0);
      chk("product_held", product, exp);
      if (b == 32'd0) chk("zero_and_only", 32'(non_and), 32'd0);
   endtask

   initial begin
      int t;
      checks = 0;
      errors = 0;
      armed  = 1'b0;
      reset  = 1'b1;
      start  = 1'b1;
      mc     = 32'hAAAA_5555;
      mp     = 32'h1234_5678;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_product", product, 32'd0);
      chk("rst_alu", alu_a | alu_b | 32'(alu_op) | 32'(alu_shamt), 32'd0);
      start = 1'b0;
      reset = 1'b0;
      armed = 1'b1;
      @(negedge clk);
      chk("idle_hold", 32'(busy), 32'd0);

      run(32'd3, 32'd5, 32'd15, 8, 0);
      run(32'h1234, 32'd0, 32'd0, 2, 0);
      run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 66, 0);
      run(32'd7, 32'h8000_0000, 32'h8000_0000, 66, 10);
      run(32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 4, 0);
      run(32'h0001_0000, 32'h0001_0000, 32'd0, 36, 0);

      // abort by reset mid-operation
      start = 1'b1;
      mc    = 32'd6;
      mp    = 32'd9;
      t     = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_at_t3", 32'(cyc), 32'(t + 3));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_product", product, 32'd0);
      @(negedge clk);
      run(32'd6, 32'd9, 32'd54, 10, 0);

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
